// File: rtl/cv32e40s_obi_data_responder.sv
// OBI data-side responder. Accepts LSU data requests, forwards non-error
// accesses to a single-cycle SRAM-style port, and returns in-order responses
// after a programmable minimum latency. Addresses inside
// [ERR_ADDR_LO, ERR_ADDR_HI] are answered with a bus error and never reach
// memory.
//
// Handshake: a transfer is accepted in a cycle where req_i && gnt_o. A
// response is delivered in a cycle where rvalid_o is high; there is no
// rready, so the master must take it. gnt_o depends only on registered state
// and gnt_stall_i, never on req_i.
module cv32e40s_obi_data_responder #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned RESP_LATENCY = 1,
    parameter logic [31:0] ERR_ADDR_LO  = 32'hFFFF_0000,
    parameter logic [31:0] ERR_ADDR_HI  = 32'hFFFF_FFFF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_i,
    output logic                       gnt_o,
    input  logic [31:0]                addr_i,
    input  logic                       we_i,
    input  logic [3:0]                 be_i,
    input  logic [31:0]                wdata_i,
    output logic                       rvalid_o,
    output logic [31:0]                rdata_o,
    output logic                       err_o,
    input  logic                       gnt_stall_i,
    input  logic                       resp_stall_i,
    output logic                       mem_req_o,
    output logic                       mem_we_o,
    output logic [31:0]                mem_addr_o,
    output logic [3:0]                 mem_be_o,
    output logic [31:0]                mem_wdata_o,
    input  logic [31:0]                mem_rdata_i,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
    output logic                       busy_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [3:0]    LAT_C    = 4'(RESP_LATENCY);
    localparam logic [3:0]    AGE_MAX  = 4'hF;

    // Response FIFO storage, one slot per outstanding transfer
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_we;
    logic [DEPTH-1:0] r_err;
    logic [DEPTH-1:0] r_pend;     // load whose read data arrives this cycle
    logic [3:0]       r_age   [DEPTH];
    logic [31:0]      r_rdata [DEPTH];

    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic             w_err_addr;
    logic             w_accept;
    logic             w_head_ready;
    logic             w_rvalid;
    logic [31:0]      w_head_data;

    // Error window decode on the incoming address (unsigned, inclusive)
    always_comb begin
        w_err_addr = (addr_i >= ERR_ADDR_LO) && (addr_i <= ERR_ADDR_HI);
    end

    // Grant, accept and memory strobe; grant looks only at the registered count
    always_comb begin
        gnt_o     = !gnt_stall_i && (r_count < DEPTH_C);
        w_accept  = req_i && gnt_o;
        mem_req_o = w_accept && !w_err_addr;
    end

    // Memory port fields follow the request directly, word-aligned address
    always_comb begin
        mem_we_o    = we_i;
        mem_addr_o  = {addr_i[31:2], 2'b00};
        mem_be_o    = be_i;
        mem_wdata_o = wdata_i;
    end

    // Head response selection; a load still in its capture cycle bypasses
    // the memory read data straight to the response
    always_comb begin
        w_head_ready = r_valid[r_rptr] && (r_age[r_rptr] >= LAT_C);
        w_rvalid     = w_head_ready && !resp_stall_i && (r_count != '0);
        w_head_data  = r_pend[r_rptr] ? mem_rdata_i : r_rdata[r_rptr];
        rvalid_o     = w_rvalid;
        rdata_o      = w_rvalid ? w_head_data : 32'h0;
        err_o        = w_rvalid ? r_err[r_rptr] : 1'b0;
    end

    // Status outputs
    always_comb begin
        outstanding_o = r_count;
        busy_o        = (r_count != '0) || req_i;
    end

    // Pointers and outstanding count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
            end
            if (w_rvalid) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(w_accept) - CW'(w_rvalid);
        end
    end

    // Slot update: aging, read-data capture, retire on response, fill on accept.
    // A new slot starts at age 1 because the grant cycle itself counts as the
    // first cycle of latency; that makes rvalid land exactly RESP_LATENCY
    // cycles after the grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_we    <= '0;
            r_err   <= '0;
            r_pend  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_age[i]   <= 4'h0;
                r_rdata[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i] && (r_age[i] != AGE_MAX)) begin
                    r_age[i] <= r_age[i] + 4'h1;
                end
                if (r_pend[i]) begin
                    r_rdata[i] <= mem_rdata_i;
                    r_pend[i]  <= 1'b0;
                end
                if (w_rvalid && (r_rptr == PW'(i))) begin
                    r_valid[i] <= 1'b0;
                end
                if (w_accept && (r_wptr == PW'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_we[i]    <= we_i;
                    r_err[i]   <= w_err_addr;
                    r_age[i]   <= 4'h1;
                    r_pend[i]  <= !we_i && !w_err_addr;
                    r_rdata[i] <= 32'h0;
                end
            end
        end
    end

    // Occupancy stays within 0..DEPTH
    a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= DEPTH_C);

    // No response from an empty responder (also rules out underflow)
    a_no_rvalid_empty : assert property (@(posedge clk) disable iff (!rst_n)
        rvalid_o |-> (r_count != '0));

    // Memory is only touched by granted transfers
    a_mem_req_gnt : assert property (@(posedge clk) disable iff (!rst_n)
        mem_req_o |-> gnt_o);

endmodule

// File: tb/tb_cv32e40s_obi_data_responder.sv
// Directed bench for cv32e40s_obi_data_responder. Two instances share the
// request inputs: u_dut_a (DEPTH=2, RESP_LATENCY=1) and u_dut_b (DEPTH=4,
// RESP_LATENCY=3). Each has its own single-cycle memory model.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 3 time units after the rising edge.
module tb_cv32e40s_obi_data_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt_stall;
  logic        resp_stall;

  logic        gnt_a, rvalid_a, err_a, mem_req_a, mem_we_a, busy_a;
  logic [31:0] rdata_a, mem_addr_a, mem_wdata_a, rd_a;
  logic [3:0]  mem_be_a;
  logic [1:0]  out_a;

  logic        gnt_b, rvalid_b, err_b, mem_req_b, mem_we_b, busy_b;
  logic [31:0] rdata_b, mem_addr_b, mem_wdata_b, rd_b;
  logic [3:0]  mem_be_b;
  logic [2:0]  out_b;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] ref_a [256];
  logic        mem_ready = 1'b0;

  logic [32:0] exp_q [$];

  int checks   = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk = ~clk;

  cv32e40s_obi_data_responder #(.DEPTH(2), .RESP_LATENCY(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt_a), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_a),
    .rdata_o(rdata_a), .err_o(err_a), .gnt_stall_i(gnt_stall),
    .resp_stall_i(resp_stall), .mem_req_o(mem_req_a), .mem_we_o(mem_we_a),
    .mem_addr_o(mem_addr_a), .mem_be_o(mem_be_a), .mem_wdata_o(mem_wdata_a),
    .mem_rdata_i(rd_a), .outstanding_o(out_a), .busy_o(busy_a)
  );

  cv32e40s_obi_data_responder #(.DEPTH(4), .RESP_LATENCY(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt_b), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_b),
    .rdata_o(rdata_b), .err_o(err_b), .gnt_stall_i(gnt_stall),
    .resp_stall_i(resp_stall), .mem_req_o(mem_req_b), .mem_we_o(mem_we_b),
    .mem_addr_o(mem_addr_b), .mem_be_o(mem_be_b), .mem_wdata_o(mem_wdata_b),
    .mem_rdata_i(rd_b), .outstanding_o(out_b), .busy_o(busy_b)
  );

  function automatic logic [31:0] init_word(input int idx);
    case (idx)
      4:       return 32'h1111_0001;
      5:       return 32'h2222_0002;
      6:       return 32'h3333_0003;
      8:       return 32'hAAAA_0008;
      9:       return 32'hBBBB_0009;
      12:      return 32'hC0C0_000C;
      13:      return 32'hD0D0_000D;
      64:      return 32'hDEAD_BEEF;
      255:     return 32'h0BAD_F00D;
      default: return {idx[7:0], 8'h5A, ~idx[7:0], 8'hC3};
    endcase
  endfunction

  // memory models: preload on first edge, byte-enabled write, registered read
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] = init_word(i);
        mem_b[i] = init_word(i);
      end
      mem_ready = 1'b1;
    end
    if (mem_req_a) begin
      if (mem_we_a) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_a[b]) mem_a[mem_addr_a[9:2]][8*b +: 8] = mem_wdata_a[8*b +: 8];
      end else begin
        rd_a <= mem_a[mem_addr_a[9:2]];
      end
    end
    if (mem_req_b) begin
      if (mem_we_b) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_b[b]) mem_b[mem_addr_b[9:2]][8*b +: 8] = mem_wdata_b[8*b +: 8];
      end else begin
        rd_b <= mem_b[mem_addr_b[9:2]];
      end
    end
  end

  // driver tasks
  task automatic set_idle();
    req = 1'b0; addr = 32'h0; we = 1'b0; be = 4'hF; wdata = 32'h0;
    gnt_stall = 1'b0; resp_stall = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic [31:0] d);
    req = r; addr = a; we = w; wdata = d; be = 4'hF;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++; if (gnt_a !== 1'b1) begin failures++; $display("FAIL reset_gnt got=%b want=1", gnt_a); end
    checks++; if (rvalid_a !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b want=0", rvalid_a); end
    checks++; if (rdata_a !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", rdata_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err_a); end
    checks++; if (mem_req_a !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b want=0", mem_req_a); end
    checks++; if (out_a !== 2'd0) begin failures++; $display("FAIL reset_outstanding got=%0d want=0", out_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    gnt_stall = 1'b1;
    #1;
    checks++; if (gnt_a !== 1'b0) begin failures++; $display("FAIL reset_gnt_stall got=%b want=0", gnt_a); end
    gnt_stall = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_load();
    do_reset();
    drive(1'b1, 32'h100, 1'b0, 32'h0);
    #2;
    checks++; if (gnt_a !== 1'b1) begin failures++; $display("FAIL single_gnt got=%b want=1", gnt_a); end
    checks++; if (mem_req_a !== 1'b1) begin failures++; $display("FAIL single_mem_req got=%b want=1", mem_req_a); end
    checks++; if (mem_addr_a !== 32'h100) begin failures++; $display("FAIL single_mem_addr got=%h want=100", mem_addr_a); end
    checks++; if (out_a !== 2'd0) begin failures++; $display("FAIL single_out0 got=%0d want=0", out_a); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    checks++; if (rvalid_a !== 1'b1) begin failures++; $display("FAIL single_rvalid got=%b want=1", rvalid_a); end
    checks++; if (rdata_a !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rdata got=%h want=deadbeef", rdata_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL single_err got=%b want=0", err_a); end
    checks++; if (out_a !== 2'd1) begin failures++; $display("FAIL single_out1 got=%0d want=1", out_a); end
    next_cycle();
    #2;
    checks++; if (rvalid_a !== 1'b0) begin failures++; $display("FAIL single_rvalid_end got=%b want=0", rvalid_a); end
    checks++; if (out_a !== 2'd0) begin failures++; $display("FAIL single_out2 got=%0d want=0", out_a); end
    next_cycle();
  endtask

  task automatic test_error_window();
    do_reset();
    drive(1'b1, 32'hFFFF_0010, 1'b0, 32'h0);
    #2;
    checks++; if (gnt_a !== 1'b1) begin failures++; $display("FAIL err_load_gnt got=%b want=1", gnt_a); end
    checks++; if (mem_req_a !== 1'b0) begin failures++; $display("FAIL err_load_mem_req got=%b want=0", mem_req_a); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    checks++; if (rvalid_a !== 1'b1 || err_a !== 1'b1) begin failures++; $display("FAIL err_load_resp got rvalid=%b err=%b want 1 1", rvalid_a, err_a); end
    checks++; if (rdata_a !== 32'h0) begin failures++; $display("FAIL err_load_rdata got=%h want=0", rdata_a); end
    next_cycle();
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h1234_5678);
    #2;
    checks++; if (mem_req_a !== 1'b0) begin failures++; $display("FAIL err_store_mem_req got=%b want=0", mem_req_a); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    checks++; if (rvalid_a !== 1'b1 || err_a !== 1'b1) begin failures++; $display("FAIL err_store_resp got rvalid=%b err=%b want 1 1", rvalid_a, err_a); end
    checks++; if (rdata_a !== 32'h0) begin failures++; $display("FAIL err_store_rdata got=%h want=0", rdata_a); end
    next_cycle();
    // just below the window: a normal load
    drive(1'b1, 32'hFFFE_FFFC, 1'b0, 32'h0);
    #2;
    checks++; if (mem_req_a !== 1'b1) begin failures++; $display("FAIL below_win_mem_req got=%b want=1", mem_req_a); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    checks++; if (rvalid_a !== 1'b1 || err_a !== 1'b0) begin failures++; $display("FAIL below_win_resp got rvalid=%b err=%b want 1 0", rvalid_a, err_a); end
    checks++; if (rdata_a !== 32'h0BAD_F00D) begin failures++; $display("FAIL below_win_rdata got=%h want=0badf00d", rdata_a); end
    next_cycle();
  endtask

  task automatic test_full();
    do_reset();
    resp_stall = 1'b1;
    drive(1'b1, 32'h13, 1'b0, 32'h0);
    #2;
    checks++; if (gnt_a !== 1'b1) begin failures++; $display("FAIL full_gnt0 got=%b want=1", gnt_a); end
    checks++; if (mem_addr_a !== 32'h10) begin failures++; $display("FAIL full_mem_addr got=%h want=10", mem_addr_a); end
    next_cycle();
    drive(1'b1, 32'h14, 1'b0, 32'h0);
    #2;
    checks++; if (gnt_a !== 1'b1) begin failures++; $display("FAIL full_gnt1 got=%b want=1", gnt_a); end
    next_cycle();
    drive(1'b1, 32'h18, 1'b0, 32'h0);
    #2;
    checks++; if (gnt_a !== 1'b0) begin failures++; $display("FAIL full_gnt2 got=%b want=0", gnt_a); end
    checks++; if (out_a !== 2'd2) begin failures++; $display("FAIL full_out got=%0d want=2", out_a); end
    checks++; if (mem_req_a !== 1'b0 || rvalid_a !== 1'b0) begin failures++; $display("FAIL full_idle got mem_req=%b rvalid=%b want 0 0", mem_req_a, rvalid_a); end
    next_cycle();
    resp_stall = 1'b0;
    #2;
    checks++; if (gnt_a !== 1'b0) begin failures++; $display("FAIL full_gnt3 got=%b want=0", gnt_a); end
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 32'h1111_0001) begin failures++; $display("FAIL full_resp0 got rvalid=%b rdata=%h want 1 11110001", rvalid_a, rdata_a); end
    next_cycle();
    #2;
    checks++; if (gnt_a !== 1'b1) begin failures++; $display("FAIL full_gnt4 got=%b want=1", gnt_a); end
    checks++; if (out_a !== 2'd1) begin failures++; $display("FAIL full_out4 got=%0d want=1", out_a); end
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 32'h2222_0002) begin failures++; $display("FAIL full_resp1 got rvalid=%b rdata=%h want 1 22220002", rvalid_a, rdata_a); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    checks++; if (out_a !== 2'd1) begin failures++; $display("FAIL full_out5 got=%0d want=1", out_a); end
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 32'h3333_0003) begin failures++; $display("FAIL full_resp2 got rvalid=%b rdata=%h want 1 33330003", rvalid_a, rdata_a); end
    next_cycle();
    #2;
    checks++; if (out_a !== 2'd0 || rvalid_a !== 1'b0) begin failures++; $display("FAIL full_drain got out=%0d rvalid=%b want 0 0", out_a, rvalid_a); end
    next_cycle();
  endtask

  task automatic test_latency();
    for (int p = 0; p < 2; p++) begin
      int x_cyc;
      x_cyc = (p == 0) ? 3 : 4;
      do_reset();
      for (int k = 0; k < 7; k++) begin
        logic exp_rv;
        logic [31:0] exp_d;
        drive(k < 2, (k == 0) ? 32'h20 : 32'h24, 1'b0, 32'h0);
        resp_stall = (p == 1) && (k == 3);
        exp_rv = (k == x_cyc) || (k == x_cyc + 1);
        exp_d  = (k == x_cyc) ? 32'hAAAA_0008 : 32'hBBBB_0009;
        #2;
        checks++; if (rvalid_b !== exp_rv) begin failures++; $display("FAIL latency_rvalid pass=%0d cyc=%0d got=%b want=%b", p, k, rvalid_b, exp_rv); end
        if (exp_rv) begin
          checks++; if (rdata_b !== exp_d) begin failures++; $display("FAIL latency_rdata pass=%0d cyc=%0d got=%h want=%h", p, k, rdata_b, exp_d); end
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(1'b1, 32'h30, 1'b0, 32'h0);
    #2;
    checks++; if (gnt_a !== 1'b1) begin failures++; $display("FAIL simul_gnt0 got=%b want=1", gnt_a); end
    next_cycle();
    drive(1'b1, 32'h34, 1'b0, 32'h0);
    #2;
    checks++; if (gnt_a !== 1'b1 || rvalid_a !== 1'b1) begin failures++; $display("FAIL simul_both got gnt=%b rvalid=%b want 1 1", gnt_a, rvalid_a); end
    checks++; if (rdata_a !== 32'hC0C0_000C) begin failures++; $display("FAIL simul_rdata0 got=%h want=c0c0000c", rdata_a); end
    checks++; if (out_a !== 2'd1) begin failures++; $display("FAIL simul_out1 got=%0d want=1", out_a); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    checks++; if (out_a !== 2'd1) begin failures++; $display("FAIL simul_out2 got=%0d want=1", out_a); end
    checks++; if (rvalid_a !== 1'b1 || rdata_a !== 32'hD0D0_000D) begin failures++; $display("FAIL simul_rdata1 got rvalid=%b rdata=%h want 1 d0d0000d", rvalid_a, rdata_a); end
    next_cycle();
    #2;
    checks++; if (out_a !== 2'd0) begin failures++; $display("FAIL simul_out3 got=%0d want=0", out_a); end
    next_cycle();
  endtask

  task automatic test_random_mix();
    int accepts = 0;
    int cyc = 0;
    logic pend = 1'b0;
    do_reset();
    for (int i = 0; i < 256; i++) ref_a[i] = mem_a[i];
    while ((accepts < 1000 || exp_q.size() != 0) && cyc < 20000) begin
      if (accepts >= 1000) begin
        req = 1'b0; gnt_stall = 1'b0; resp_stall = 1'b0;
      end else begin
        if (!pend) begin
          req = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 7) == 0)
            addr = 32'hFFFF_0000 | ($urandom_range(0, 16383) << 2);
          else
            addr = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
          we    = $urandom_range(0, 1);
          be    = 4'($urandom_range(1, 15));
          wdata = $urandom;
        end
        gnt_stall  = ($urandom_range(0, 4) == 0);
        resp_stall = ($urandom_range(0, 3) == 0);
      end
      #2;
      if (rvalid_a) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rand_unexpected_rvalid got rdata=%h err=%b want no response", rdata_a, err_a);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          checks++;
          if (rdata_a !== e[31:0] || err_a !== e[32]) begin
            failures++;
            $display("FAIL rand_resp got rdata=%h err=%b want rdata=%h err=%b", rdata_a, err_a, e[31:0], e[32]);
          end
        end
      end
      if (req && gnt_a) begin
        logic in_err;
        in_err = (addr >= 32'hFFFF_0000);
        if (in_err) exp_q.push_back({1'b1, 32'h0});
        else if (we) exp_q.push_back({1'b0, 32'h0});
        else exp_q.push_back({1'b0, ref_a[addr[9:2]]});
        if (we && !in_err)
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_a[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
        accepts++;
        pend = 1'b0;
      end else begin
        pend = req;
      end
      cyc++;
      next_cycle();
    end
    checks++;
    if (cyc >= 20000) begin
      failures++;
      $display("FAIL rand_timeout got accepts=%0d pending=%0d want 1000 and 0", accepts, exp_q.size());
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    resp_stall = 1'b1;
    drive(1'b1, 32'h0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 32'h4, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    checks++; if (out_a !== 2'd2) begin failures++; $display("FAIL rstmid_pre_out got=%0d want=2", out_a); end
    next_cycle();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      #2;
      checks++; if (rvalid_a !== 1'b0 || out_a !== 2'd0) begin failures++; $display("FAIL rstmid_stale cyc=%0d got rvalid=%b out=%0d want 0 0", k, rvalid_a, out_a); end
      next_cycle();
    end
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // test sequence and final report
  initial begin
    set_idle();
    rst_n = 1'b0;
    test_reset();
    test_single_load();
    test_error_window();
    test_full();
    test_latency();
    test_simultaneous();
    test_random_mix();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
